// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg -- MIPS coprocessor-0 register file.
//
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14).
// It takes the exception report from MEM and mtc0 writes from WB. It returns
// Status/Cause/EPC to MEM so that MEM can resolve exceptions. It also owns
// the Count/Compare timer and the interrupt request.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   int_i[5:0]              level-sensitive hardware interrupts
//   we_i/waddr_i/wdata_i    mtc0 write from WB
//   raddr_i/rdata_o         mfc0 read, combinational, pre-edge state
//   excepttype_i            MEM exception code (0 = none, 0x0e = eret)
//   current_inst_addr_i     PC of the MEM instruction
//   is_in_delayslot_i       MEM instruction sits in a delay slot
//   bad_addr_i              faulting address for AdEL/AdES
//   status_o..compare_o     current register values
//   timer_int_o             sticky timer interrupt
//   int_req_o               interrupt request to MEM
// ---------------------------------------------------------------------------
module cp0_reg #(
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o,
    output logic        int_req_o
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;

    // Status: only IM[15:8], EXL and IE are writable. BEV always reads 1.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

    // COUNT_DIV is 1 or 2, so a 1-bit phase counter is enough.
    localparam logic        DIV_LAST     = 1'(COUNT_DIV - 1);

    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        timer_int;
    logic        div_cnt;

    logic        div_tick;
    logic        exc_take;
    logic        exc_eret;
    logic        exc_badaddr;
    logic [4:0]  exc_code;
    logic        wr_count;
    logic        wr_compare;

    assign div_tick   = (div_cnt == DIV_LAST);
    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);

    // Map the MEM exception code to an ExcCode. Any unknown nonzero code is
    // dropped and causes no state change.
    always_comb begin
        exc_take    = 1'b0;
        exc_eret    = 1'b0;
        exc_badaddr = 1'b0;
        exc_code    = 5'd0;
        case (excepttype_i)
            32'h0000_0001: begin exc_take = 1'b1; exc_code = 5'h00; end
            32'h0000_0004: begin exc_take = 1'b1; exc_code = 5'h04; exc_badaddr = 1'b1; end
            32'h0000_0005: begin exc_take = 1'b1; exc_code = 5'h05; exc_badaddr = 1'b1; end
            32'h0000_0008: begin exc_take = 1'b1; exc_code = 5'h08; end
            32'h0000_0009: begin exc_take = 1'b1; exc_code = 5'h09; end
            32'h0000_000a: begin exc_take = 1'b1; exc_code = 5'h0a; end
            32'h0000_000c: begin exc_take = 1'b1; exc_code = 5'h0c; end
            32'h0000_000e: exc_eret = 1'b1;
            default: ;
        endcase
    end

    // Count/Compare timer. An mtc0 to Count overrides the tick, and the
    // divider phase keeps running. Clearing the timer beats setting it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_cnt   <= 1'b0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            div_cnt <= div_tick ? 1'b0 : div_cnt + 1'b1;
            if (wr_count)
                count <= wdata_i;
            else if (div_tick)
                count <= count + 32'd1;
            if (wr_compare)
                compare <= wdata_i;
            if (wr_compare)
                timer_int <= 1'b0;
            else if (count == compare && compare != '0)
                timer_int <= 1'b1;
        end
    end

    // Status/Cause/EPC/BadVAddr. The mtc0 assignments come first. The later
    // exception assignments win on the fields they touch, because the last
    // nonblocking write to a bit takes effect. The EXL test reads the pre-edge
    // Status, so a nested exception keeps the original EPC and BD.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            badvaddr <= '0;
            status   <= STATUS_RST;
            cause    <= '0;
            epc      <= '0;
        end else begin
            cause[15:10] <= {int_i[5] | timer_int, int_i[4:0]};

            if (we_i) begin
                case (waddr_i)
                    REG_STATUS: status     <= (wdata_i & STATUS_WMASK) | STATUS_BEV;
                    REG_CAUSE:  cause[9:8] <= wdata_i[9:8];
                    REG_EPC:    epc        <= wdata_i;
                    default: ;
                endcase
            end

            if (exc_take) begin
                if (!status[1]) begin
                    epc       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                   : current_inst_addr_i;
                    cause[31] <= is_in_delayslot_i;
                end
                status[1]   <= 1'b1;
                cause[6:2]  <= exc_code;
                if (exc_badaddr)
                    badvaddr <= bad_addr_i;
            end else if (exc_eret) begin
                status[1] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = badvaddr;
            REG_COUNT:    rdata_o = count;
            REG_COMPARE:  rdata_o = compare;
            REG_STATUS:   rdata_o = status;
            REG_CAUSE:    rdata_o = cause;
            REG_EPC:      rdata_o = epc;
            default: ;
        endcase
    end

    assign status_o    = status;
    assign cause_o     = cause;
    assign epc_o       = epc;
    assign count_o     = count;
    assign compare_o   = compare;
    assign timer_int_o = timer_int;
    assign int_req_o   = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

endmodule

// File: tb/tb_cp0_reg.sv
// ---------------------------------------------------------------------------
// tb_cp0_reg -- scoreboard bench for cp0_reg.
// The stimulus drives one cycle at each falling edge. It advances a reference
// model of the architectural state and queues the expected post-edge outputs.
// A monitor pops one entry after each rising edge and compares it. Directed
// scenarios add checks against fixed constants.
// ---------------------------------------------------------------------------
module tb_cp0_reg;

    localparam int COUNT_DIV = 2;

    typedef struct {
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] count;
        logic [31:0] compare;
        logic        timer;
        logic        int_req;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [5:0]  int_i = '0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] rdata_o;
    logic [31:0] excepttype_i = '0;
    logic [31:0] current_inst_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [31:0] bad_addr_i = '0;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o;
    logic        timer_int_o, int_req_o;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_badv, m_count, m_cmp, m_status, m_cause, m_epc;
    logic        m_timer;
    int          m_phase;

    cp0_reg #(.COUNT_DIV(COUNT_DIV), .STATUS_RST(32'h0040_0000)) dut (
        .clk_i(clk), .rst_i(rst_i), .int_i(int_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .excepttype_i(excepttype_i), .current_inst_addr_i(current_inst_addr_i),
        .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .count_o(count_o), .compare_o(compare_o),
        .timer_int_o(timer_int_o), .int_req_o(int_req_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra);
        case (ra)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // One clock of stimulus. The model computes the next state from the
    // previous state: first the timer and interrupt sampling, then mtc0,
    // then the exception.
    task automatic step(input logic rst, input logic [5:0] irq, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra,
                        input logic [31:0] et, input logic [31:0] pc, input logic ds,
                        input logic [31:0] bad);
        exp_t e;
        logic [31:0] n_badv, n_count, n_cmp, n_status, n_cause, n_epc;
        logic        n_timer, take, eret;
        logic [4:0]  code;
        @(negedge clk);
        rst_i = rst; int_i = irq; we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra;
        excepttype_i = et; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
        if (!rst) begin
            m_badv = 0; m_count = 0; m_cmp = 0; m_status = 32'h0040_0000;
            m_cause = 0; m_epc = 0; m_timer = 0; m_phase = 0;
        end else begin
            n_badv = m_badv; n_count = m_count; n_cmp = m_cmp; n_status = m_status;
            n_cause = m_cause; n_epc = m_epc; n_timer = m_timer;
            if (m_phase == COUNT_DIV - 1) begin
                n_count = m_count + 1;
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
            if (m_count == m_cmp && m_cmp != 0) n_timer = 1'b1;
            n_cause[15:10] = {irq[5] | m_timer, irq[4:0]};
            if (we) begin
                case (wa)
                    5'd9:  n_count = wd;
                    5'd11: begin n_cmp = wd; n_timer = 1'b0; end
                    5'd12: n_status = (wd & 32'h0000_ff03) | 32'h0040_0000;
                    5'd13: n_cause[9:8] = wd[9:8];
                    5'd14: n_epc = wd;
                    default: ;
                endcase
            end
            take = 1'b0; eret = 1'b0; code = 5'd0;
            case (et)
                32'h1:                          begin take = 1'b1; code = 5'd0; end
                32'h4, 32'h5, 32'h8, 32'h9,
                32'ha, 32'hc:                   begin take = 1'b1; code = et[4:0]; end
                32'he:                          eret = 1'b1;
                default: ;
            endcase
            if (take) begin
                if (!m_status[1]) begin
                    n_epc = ds ? pc - 32'd4 : pc;
                    n_cause[31] = ds;
                end
                n_status[1] = 1'b1;
                n_cause[6:2] = code;
                if (code == 5'd4 || code == 5'd5) n_badv = bad;
            end
            if (eret) n_status[1] = 1'b0;
            m_badv = n_badv; m_count = n_count; m_cmp = n_cmp; m_status = n_status;
            m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
        end
        e.status = m_status; e.cause = m_cause; e.epc = m_epc; e.count = m_count;
        e.compare = m_cmp; e.timer = m_timer;
        e.int_req = m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
        e.rdata = model_read(ra);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    // monitor: one expected entry per rising edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("sb_status",  status_o,    e.status);
                cmp("sb_cause",   cause_o,     e.cause);
                cmp("sb_epc",     epc_o,       e.epc);
                cmp("sb_count",   count_o,     e.count);
                cmp("sb_compare", compare_o,   e.compare);
                cmp("sb_timer",   {31'b0, timer_int_o}, {31'b0, e.timer});
                cmp("sb_int_req", {31'b0, int_req_o},   {31'b0, e.int_req});
                cmp("sb_rdata",   rdata_o,     e.rdata);
            end
        end
    end

    initial begin : stim
        int n;
        logic [31:0] et_tab [15];
        et_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h4, 32'h5, 32'h8,
                   32'h9, 32'ha, 32'hc, 32'he, 32'h2, 32'h3, 32'h0};

        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        cmp("rst_status", status_o, 32'h0040_0000);
        cmp("rst_cause",  cause_o,  32'h0);
        cmp("rst_timer",  {31'b0, timer_int_o}, 32'h0);

        // 10 cycles at divide-by-2
        idle(10);
        settle();
        cmp("count_div", count_o, 32'd5);

        // timer: Compare=8, Count=0
        step(1, 0, 1, 5'd11, 32'd8, 0, 0, 0, 0, 0);
        step(1, 0, 1, 5'd9,  32'd0, 0, 0, 0, 0, 0);
        settle();
        n = 0;
        while (timer_int_o !== 1'b1 && n < 40) begin
            idle(1); settle(); n++;
        end
        cmp("timer_set", {31'b0, timer_int_o}, 32'h1);
        idle(1); settle();
        cmp("cause_ip7_timer", {31'b0, cause_o[15]}, 32'h1);
        step(1, 0, 1, 5'd11, 32'h20, 0, 0, 0, 0, 0);
        settle();
        cmp("timer_clear", {31'b0, timer_int_o}, 32'h0);

        // syscall in a delay slot, then a nested exception
        step(1, 0, 0, 0, 0, 0, 32'h8, 32'hbfc0_0100, 1, 0);
        settle();
        cmp("sys_epc", epc_o, 32'hbfc0_00fc);
        cmp("sys_bd",  {31'b0, cause_o[31]}, 32'h1);
        cmp("sys_code", {27'b0, cause_o[6:2]}, 32'h8);
        cmp("sys_exl", {31'b0, status_o[1]}, 32'h1);
        step(1, 0, 0, 0, 0, 0, 32'h8, 32'h0000_0100, 0, 0);
        settle();
        cmp("nested_epc", epc_o, 32'hbfc0_00fc);

        // AdEL, then eret
        step(1, 0, 0, 0, 0, 5'd8, 32'h4, 32'h0000_0200, 0, 32'h8000_0003);
        settle();
        cmp("adel_badv", rdata_o, 32'h8000_0003);
        cmp("adel_code", {27'b0, cause_o[6:2]}, 32'h4);
        step(1, 0, 0, 0, 0, 0, 32'he, 0, 0, 0);
        settle();
        cmp("eret_exl", {31'b0, status_o[1]}, 32'h0);
        cmp("eret_epc", epc_o, 32'hbfc0_00fc);

        // external interrupt on IP2, then masked by EXL
        step(1, 6'b000001, 1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0);
        settle();
        cmp("ip2_cause", {31'b0, cause_o[10]}, 32'h1);
        cmp("int_req_on", {31'b0, int_req_o}, 32'h1);
        step(1, 6'b000001, 0, 0, 0, 0, 32'h1, 32'h300, 0, 0);
        settle();
        cmp("int_req_exl", {31'b0, int_req_o}, 32'h0);

        // mtc0 Status together with overflow in the same cycle
        step(1, 0, 1, 5'd12, 32'h0, 0, 32'hc, 32'h400, 0, 0);
        settle();
        cmp("combo_status", status_o, 32'h0040_0002);
        cmp("combo_code", {27'b0, cause_o[6:2]}, 32'hc);
        step(1, 0, 1, 5'd8, 32'h1234_5678, 5'd8, 0, 0, 0, 0);
        settle();
        cmp("badv_ro", rdata_o, 32'h8000_0003);
        step(1, 0, 0, 0, 0, 5'd3, 0, 0, 0, 0);
        settle();
        cmp("rd_unmapped", rdata_o, 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r_rst, r_we, r_ds;
            logic [4:0]  r_wa, r_ra;
            logic [31:0] r_wd, r_et;
            r_rst = ($urandom_range(0, 149) != 0);
            r_we  = $urandom_range(0, 1);
            r_wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 15));
            r_wd  = $urandom;
            if ((r_wa == 5'd9 || r_wa == 5'd11) && $urandom_range(0, 1)) r_wd = $urandom_range(0, 40);
            if (r_wa == 5'd12 && $urandom_range(0, 1)) r_wd = r_wd & 32'hffff_fffc | 32'h1;
            r_ra  = 5'($urandom_range(0, 15));
            r_et  = et_tab[$urandom_range(0, 14)];
            if ($urandom_range(0, 30) == 0) r_et = $urandom;
            r_ds  = $urandom_range(0, 1);
            step(r_rst, 6'($urandom), r_we, r_wa, r_wd, r_ra, r_et, $urandom, r_ds, $urandom);
        end

        idle(2);
        settle();
        settle();
        cmp("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
